// File: rtl/clp_lcd_responder.sv
// HD44780-style character LCD controller model: decodes the 8-bit parallel bus,
// keeps a 128-byte DDRAM, emulates busy timing and answers status/data reads.
module clp_lcd_responder #(
    parameter int unsigned CMD_CYC   = 4000,
    parameter int unsigned CLEAR_CYC = 164000,
    parameter int unsigned BUSY_W    = 18
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] lcd_db_in,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    output logic [7:0] lcd_db_out,
    output logic       lcd_db_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_id,
    output logic       entry_s,
    output logic       func_dl,
    output logic       func_n,
    output logic [5:0] shift_ofs,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       overrun
);

    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 8;
    localparam int unsigned OFS_W = 6;
    localparam logic [DW-1:0]    BLANK   = 8'h20;
    localparam logic [OFS_W-1:0] OFS_MAX = 6'd39;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [BUSY_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [AW-1:0]     ac_q, ac_d;
    logic              disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic              id_q, id_d, s_q, s_d, dl_q, dl_d, n_q, n_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;
    logic              overrun_q, overrun_d, busy_q, busy_d;
    logic [DW-1:0]     db_out_q, db_out_d;
    logic              db_oe_q, db_oe_d;
    logic [DW-1:0]     rd_data_q;
    logic [DW-1:0]     mem_q [DEPTH];

    logic          e_meta_q, e_sync_q, e_prev_q;
    logic          rs_q, rw_q;
    logic [DW-1:0] db_q;
    logic          e_rise, e_fall, rs_n, rw_n;
    logic          mem_we, cmd_go;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // Address counter step; two-line mode jumps between the 0x00-0x27 and 0x40-0x67 banks.
    function automatic logic [AW-1:0] ac_step(input logic [AW-1:0] a, input logic inc,
                                              input logic two_line);
        logic [AW-1:0] r;
        r = inc ? a + 7'd1 : a - 7'd1;
        if (!two_line) begin
            if (inc && a == 7'h4F)       r = 7'h00;
            else if (!inc && a == 7'h00) r = 7'h4F;
        end else begin
            if (inc && a == 7'h27)       r = 7'h40;
            else if (inc && a == 7'h67)  r = 7'h00;
            else if (!inc && a == 7'h40) r = 7'h27;
            else if (!inc && a == 7'h00) r = 7'h67;
        end
        return r;
    endfunction

    function automatic logic [OFS_W-1:0] ofs_step(input logic [OFS_W-1:0] o, input logic inc);
        logic [OFS_W-1:0] r;
        if (inc) r = (o == OFS_MAX) ? 6'd0 : o + 6'd1;
        else     r = (o == 6'd0) ? OFS_MAX : o - 6'd1;
        return r;
    endfunction

    assign e_rise = e_sync_q & ~e_prev_q;
    assign e_fall = ~e_sync_q & e_prev_q;
    assign rs_n   = e_rise ? lcd_rs : rs_q;
    assign rw_n   = e_rise ? lcd_rw : rw_q;

    // Synchronize E and capture the bus on its rising edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            e_meta_q <= 1'b0;
            e_sync_q <= 1'b0;
            e_prev_q <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            db_q     <= '0;
        end else begin
            e_meta_q <= lcd_e;
            e_sync_q <= e_meta_q;
            e_prev_q <= e_sync_q;
            rs_q     <= rs_n;
            rw_q     <= rw_n;
            if (e_rise) db_q <= lcd_db_in;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            clr_ptr_q <= '0;
            ac_q      <= '0;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            id_q      <= 1'b1;
            s_q       <= 1'b0;
            dl_q      <= 1'b1;
            n_q       <= 1'b0;
            ofs_q     <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            db_out_q  <= '0;
            db_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_ptr_q <= clr_ptr_d;
            ac_q      <= ac_d;
            disp_q    <= disp_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            id_q      <= id_d;
            s_q       <= s_d;
            dl_q      <= dl_d;
            n_q       <= n_d;
            ofs_q     <= ofs_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
            db_out_q  <= db_out_d;
            db_oe_q   <= db_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_ptr_d = clr_ptr_q;
        ac_d      = ac_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        id_d      = id_q;
        s_d       = s_q;
        dl_d      = dl_q;
        n_d       = n_q;
        ofs_d     = ofs_q;
        overrun_d = overrun_q;
        mem_we    = 1'b0;
        mem_waddr = ac_q;
        mem_wdata = db_q;
        cmd_go    = 1'b0;

        db_oe_d  = e_sync_q & rw_n;
        db_out_d = '0;
        if (db_oe_d) db_out_d = rs_n ? mem_q[ac_q] : {busy_q, ac_q};

        if (e_fall) begin
            if (rw_q) begin
                if (rs_q) ac_d = ac_step(ac_q, id_q, n_q);
            end else if (state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end else if (rs_q) begin
                mem_we = 1'b1;
                ac_d   = ac_step(ac_q, id_q, n_q);
                if (s_q) ofs_d = ofs_step(ofs_q, id_q);
                cmd_go = 1'b1;
            end else begin
                casez (db_q)
                    8'b1???????: begin ac_d = db_q[6:0]; cmd_go = 1'b1; end
                    8'b01??????: cmd_go = 1'b1;
                    8'b001?????: begin dl_d = db_q[4]; n_d = db_q[3]; cmd_go = 1'b1; end
                    8'b0001????: begin
                        if (db_q[3]) ofs_d = ofs_step(ofs_q, db_q[2]);
                        else         ac_d  = ac_step(ac_q, db_q[2], n_q);
                        cmd_go = 1'b1;
                    end
                    8'b00001???: begin
                        disp_d  = db_q[2];
                        cur_d   = db_q[1];
                        blink_d = db_q[0];
                        cmd_go  = 1'b1;
                    end
                    8'b000001??: begin id_d = db_q[1]; s_d = db_q[0]; cmd_go = 1'b1; end
                    8'b0000001?: begin
                        ac_d    = '0;
                        ofs_d   = '0;
                        state_d = ST_BUSY;
                        cnt_d   = BUSY_W'(CLEAR_CYC);
                    end
                    8'b00000001: begin
                        state_d   = ST_CLEAR;
                        cnt_d     = BUSY_W'(CLEAR_CYC);
                        clr_ptr_d = '0;
                    end
                    default: ;
                endcase
            end
        end

        if (cmd_go) begin
            state_d = ST_BUSY;
            cnt_d   = BUSY_W'(CMD_CYC);
        end

        // Countdown after the commit so the end of a clear sweep wins over a concurrent read step.
        case (state_q)
            ST_BUSY: begin
                cnt_d = cnt_q - BUSY_W'(1);
                if (cnt_q <= BUSY_W'(1)) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                cnt_d     = cnt_q - BUSY_W'(1);
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = BLANK;
                clr_ptr_d = clr_ptr_q + 7'd1;
                if (clr_ptr_q == 7'h7F) begin
                    ac_d    = '0;
                    id_d    = 1'b1;
                    ofs_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // DDRAM with blank fill on reset and a registered inspection port.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= BLANK;
            rd_data_q <= '0;
        end else begin
            if (mem_we) mem_q[mem_waddr] <= mem_wdata;
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign lcd_db_out = db_out_q;
    assign lcd_db_oe  = db_oe_q;
    assign busy       = busy_q;
    assign ac         = ac_q;
    assign disp_on    = disp_q;
    assign cursor_on  = cur_q;
    assign blink_on   = blink_q;
    assign entry_id   = id_q;
    assign entry_s    = s_q;
    assign func_dl    = dl_q;
    assign func_n     = n_q;
    assign shift_ofs  = ofs_q;
    assign rd_data    = rd_data_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/clp_lcd_responder.md
Name: clp_lcd_responder

Overview:
- Models the HD44780-compatible controller on the PmodCLP character LCD, i.e. the receiving end of the 8-bit parallel bus the PmodCLP driver produces on JB (DB7..0) and JC (RS, RW, E).
- Decodes instructions, stores data into a 128-byte DDRAM, emulates busy timing and answers bus reads.
- Synthesizable; used as an on-chip loopback target and as a bench responder for driver verification.

Parameters:
CMD_CYC, 4000, busy cycles after any non-clear/home instruction or data write (40 us at 100 MHz)
CLEAR_CYC, 164000, busy cycles after Clear Display / Return Home (>=130 required)
BUSY_W, 18, busy counter width (must hold CLEAR_CYC)

Ports:
CLK  in  1  system clock
RSTN  in  1  asynchronous active-low reset
lcd_db_in  in  8  DB7..0 from driver
lcd_rs  in  1  register select (0 instr/status, 1 data)
lcd_rw  in  1  1 = read, 0 = write
lcd_e  in  1  enable strobe, asynchronous to CLK
lcd_db_out  out  8  read data to driver
lcd_db_oe  out  1  drive enable for lcd_db_out
busy  out  1  busy flag
ac  out  7  address counter
disp_on, cursor_on, blink_on  out  1 each  display control bits D, C, B
entry_id, entry_s  out  1 each  entry mode I/D, S
func_dl, func_n  out  1 each  function set DL, N
shift_ofs  out  6  display shift offset, 0..39
rd_addr  in  7  DDRAM inspection address
rd_data  out  8  DDRAM[rd_addr], registered, 1-cycle latency
overrun  out  1  sticky: write committed while busy

Behaviour:
- Reset (RSTN low, async): all DDRAM = 0x20; ac=0; busy=0; disp_on=cursor_on=blink_on=0; entry_id=1; entry_s=0; func_dl=1; func_n=0; shift_ofs=0; lcd_db_out=0; lcd_db_oe=0; overrun=0; rd_data=0; state IDLE. Reset mid-clear aborts the sweep. Reset itself performs the 0x20 fill.
- lcd_e passes through a 2-flop synchronizer. lcd_rs, lcd_rw and lcd_db_in are latched into hold registers on the synchronized E rising edge.
- A transaction commits on the synchronized E falling edge, using the hold registers. E pulses shorter than 2 CLK may be missed; this is legal.
- Status read (RW=1, RS=0): while synced E is high, lcd_db_oe=1 and lcd_db_out={busy, ac}. There is no side effect.
- Data read (RW=1, RS=1): while synced E is high, lcd_db_out=DDRAM[ac]. At commit, ac steps by entry_id. Busy is not set.
- Writes (RW=0) arriving while busy=1 are discarded and set overrun. Otherwise they are decoded as follows.
- Data write (RS=1): DDRAM[ac] <= DB; ac steps. If entry_s=1, shift_ofs steps by ±1 mod 40 (+1 when I/D=1).
- Instruction write (RS=0) decodes by the highest set bit:
  - DB7: ac <= DB[6:0].
  - DB6: set CGRAM address; accepted, no state change.
  - DB5: func_dl <= DB4; func_n <= DB3.
  - DB4: if DB3=1, shift_ofs ±1 mod 40 (DB2=1 right, +1); else ac steps (DB2=1 +1).
  - DB3: disp_on <= DB2; cursor_on <= DB1; blink_on <= DB0.
  - DB2: entry_id <= DB1; entry_s <= DB0.
  - DB1: return home; ac=0, shift_ofs=0.
  - DB0: clear display.
  - DB=0x00: no-op, no busy.
- ac stepping:
  - func_n=0: range 0x00..0x4F, wraps 0x4F<->0x00.
  - func_n=1: 0x27 +1 -> 0x40; 0x67 +1 -> 0x00; decrement is the exact reverse.
  - Explicit DB7 loads are stored unmodified.
- Busy timing: busy=1 starting the cycle after commit. The counter is loaded with CMD_CYC, or CLEAR_CYC for home/clear, and busy deasserts when it reaches 0.
- FSM:
  - IDLE: no busy period active.
  - BUSY: counting down; returns to IDLE at 0.
  - CLEAR: writes 0x20 to DDRAM[0..127], one location per cycle, while counting. It then sets ac=0, entry_id=1, shift_ofs=0 and moves to BUSY for the remaining count. Total busy time is always CLEAR_CYC.
- A status read during any busy state returns busy=1.

Test Plan:
- Reset, then status read -> lcd_db_out=0x00, oe=1 only while E high; rd_data at 0x05 = 0x20.
- Write instr 0x38, 0x0F, 0x06, then wait -> func_dl=1, func_n=1, disp/cursor/blink=1, entry_id=1, entry_s=0; busy high CMD_CYC cycles after each.
- Instr 0xA7 (ac=0x27), data 0x31 then 0x32 -> DDRAM[0x27]=0x31, DDRAM[0x40]=0x32, ac=0x41.
- Write data 0x30 immediately after previous write, no busy wait -> DDRAM unchanged, overrun=1.
- Fill data, then instr 0x01 -> busy stays high for exactly CLEAR_CYC cycles; afterward all 128 DDRAM = 0x20, ac=0, entry_id=1.
- Data read at ac=0x4F with func_n=0, entry_id=1 -> lcd_db_out=DDRAM[0x4F], ac wraps to 0x00. Also assert RSTN during CLEAR -> immediate reset values.
